reg_file_scoreboard: RTL
========================

# reg_file_scoreboard

Parametrised successor to the datapath register file: depth and data width are set by parameters, reads have optional write-through bypass, and register 0 can be hardwired to zero. It adds a per-register busy scoreboard for hazard detection, and a sequential clear engine that zeroes the array one entry per cycle. It sits between decode/issue (read, issue) and writeback (write) in the datapath.

## Interface
- N, 32, data width in bits
- ADDR_W, 5, register address width; DEPTH = 2^ADDR_W entries
- ZERO_REG, 1, 1 = entry 0 always reads 0, ignores writes, and is never busy
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-low reset (sampled on the rising edge of clk)
- Reg_Write_i  in  1  write enable
- Write_Register_i  in  ADDR_W  write address
- Write_Data_i  in  N  write data
- Read_Register_1_i / Read_Register_2_i  in  ADDR_W  read addresses
- Read_Data_1_o / Read_Data_2_o  out  N  combinational read data
- Issue_Valid_i  in  1  marks Issue_Dest_i as having a pending producer
- Issue_Dest_i  in  ADDR_W  destination being issued
- Busy_1_o / Busy_2_o  out  1  read operand is not yet available
- Clear_Req_i  in  1  starts a clear sweep
- Clear_Busy_o  out  1  sweep in progress; upstream must stall writes and issues

## Operation
- Storage: DEPTH x N data array, a DEPTH-bit busy vector, a 2-state FSM (IDLE, SWEEP), and an ADDR_W-bit sweep counter.
- Reset (reset == 0 at the edge):
  - all entries = 0, busy = 0, FSM = IDLE, counter = 0.
  - Hence Clear_Busy_o = 0, Busy_x_o = 0, Read_Data_x_o = 0.
- Write (IDLE, Reg_Write_i = 1):
  - entry[Write_Register_i] <= Write_Data_i.
  - busy[Write_Register_i] <= 0.
  - Addr 0 is ignored when ZERO_REG = 1.
- Issue (IDLE, Issue_Valid_i = 1): busy[Issue_Dest_i] <= 1. Addr 0 is ignored when ZERO_REG = 1.
- Write and issue to the same addr in the same cycle: data is written and busy ends at 1 (the new producer wins).
- Read port k (combinational):
  - ZERO_REG = 1 and addr = 0: data 0, busy 0.
  - Otherwise, if BYPASS = 1, FSM = IDLE, Reg_Write_i = 1 and Write_Register_i = addr: data = Write_Data_i, busy 0.
  - Otherwise: data = entry[addr], busy = busy[addr].
- FSM:
  - IDLE -> SWEEP when Clear_Req_i = 1; counter <= 0. A write or issue in that same cycle still takes effect.
  - SWEEP, each cycle: entry[counter] <= 0, busy[counter] <= 0, counter <= counter + 1.
  - SWEEP -> IDLE in the cycle counter = DEPTH-1; the counter wraps to 0.
  - Clear_Busy_o = (FSM == SWEEP).
- During SWEEP:
  - Reg_Write_i, Issue_Valid_i and Clear_Req_i are ignored; no restart occurs.
  - Bypass is disabled; reads return current array contents, whether already cleared or not.
- Reset mid-sweep: the next state is IDLE with everything zeroed. Reset has priority over all other inputs.

## Timing
- Write latency: 1 cycle to the array. 0 cycles through bypass (BYPASS = 1), or 1 cycle (BYPASS = 0).
- Issue busy is visible the cycle after Issue_Valid_i.
- A writeback clears busy for the same-cycle read through bypass; otherwise from the next cycle.
- Clear sweep:
  - Clear_Busy_o rises 1 cycle after Clear_Req_i is sampled and stays high for exactly DEPTH cycles.
  - Entry i reads 0 from cycle i+2 after the request.
- No combinational path from Clear_Req_i to any output.

## Test plan
- Reset: hold reset = 0 for 2 cycles, then release -> both reads of addrs 0..31 return 0, Busy_x_o = 0, Clear_Busy_o = 0.
- Write/bypass: write 0xDEADBEEF to r5 with Read_Register_1_i = 5 in the same cycle -> Read_Data_1_o = 0xDEADBEEF in that cycle (BYPASS = 1), and in the next cycle. With BYPASS = 0 -> previous value, then 0xDEADBEEF one cycle later.
- Zero register: write 0x12345678 to r0 and issue r0 -> Read_Data_x_o = 0, Busy_x_o = 0.
- Scoreboard: issue r7 -> Busy_1_o = 1 next cycle (Read_Register_1_i = 7). Write r7 = 0xA5 -> Busy_1_o = 0 and data 0xA5 in the same cycle. Issue and write r9 together -> r9 = written data, Busy = 1.
- Clear sweep: fill r1..r31 with i, pulse Clear_Req_i -> Clear_Busy_o high for exactly 32 cycles. r10 reads 10 until cycle 11 after the request, then 0. A write to r3 during the sweep is ignored. All entries are 0 at the end.
- Reset mid-sweep: assert reset at sweep cycle 15 -> Clear_Busy_o = 0 next cycle, all entries 0, and a new Clear_Req_i starts the sweep from entry 0.

Source files
------------

// File: rtl/reg_file_scoreboard_if.sv
// reg_file_scoreboard_if: read/write/issue/clear bus of the scoreboarded register file
interface reg_file_scoreboard_if #(parameter int N = 32, parameter int ADDR_W = 5);
  logic              Reg_Write_i;
  logic [ADDR_W-1:0] Write_Register_i;
  logic [N-1:0]      Write_Data_i;
  logic [ADDR_W-1:0] Read_Register_1_i;
  logic [ADDR_W-1:0] Read_Register_2_i;
  logic [N-1:0]      Read_Data_1_o;
  logic [N-1:0]      Read_Data_2_o;
  logic              Issue_Valid_i;
  logic [ADDR_W-1:0] Issue_Dest_i;
  logic              Busy_1_o;
  logic              Busy_2_o;
  logic              Clear_Req_i;
  logic              Clear_Busy_o;
  modport master (
    output Reg_Write_i, Write_Register_i, Write_Data_i, Read_Register_1_i, Read_Register_2_i,
           Issue_Valid_i, Issue_Dest_i, Clear_Req_i,
    input  Read_Data_1_o, Read_Data_2_o, Busy_1_o, Busy_2_o, Clear_Busy_o
  );
  modport slave (
    input  Reg_Write_i, Write_Register_i, Write_Data_i, Read_Register_1_i, Read_Register_2_i,
           Issue_Valid_i, Issue_Dest_i, Clear_Req_i,
    output Read_Data_1_o, Read_Data_2_o, Busy_1_o, Busy_2_o, Clear_Busy_o
  );
endinterface

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: parametrised register file with busy scoreboard, write bypass and clear sweep
module reg_file_scoreboard #(
  parameter int N        = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input logic clk,
  input logic reset,
  reg_file_scoreboard_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  typedef enum logic {IDLE, SWEEP} state_t;
  state_t            state_q, state_d;
  logic [N-1:0]      mem_q [DEPTH];
  logic [N-1:0]      mem_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              wr_en, iss_en;
  always_comb begin
    wr_en   = state_q == IDLE && bus.Reg_Write_i && !(ZERO_REG && bus.Write_Register_i == '0);
    iss_en  = state_q == IDLE && bus.Issue_Valid_i && !(ZERO_REG && bus.Issue_Dest_i == '0);
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;
    busy_d  = busy_q;
    if (state_q == IDLE) begin
      if (wr_en) begin
        mem_d[bus.Write_Register_i]  = bus.Write_Data_i;
        busy_d[bus.Write_Register_i] = 1'b0;
      end
      // issue after write so a same-cycle new producer keeps the entry busy
      if (iss_en) busy_d[bus.Issue_Dest_i] = 1'b1;
      if (bus.Clear_Req_i) begin
        state_d = SWEEP;
        cnt_d   = '0;
      end
    end else begin
      mem_d[cnt_q]  = '0;
      busy_d[cnt_q] = 1'b0;
      cnt_d         = cnt_q + 1'b1;
      state_d       = &cnt_q ? IDLE : SWEEP;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= '0;
      mem_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      mem_q   <= mem_d;
    end
  end
  function automatic logic [N:0] rd(input logic [ADDR_W-1:0] a);
    return (ZERO_REG && a == '0) ? '0 :
           (BYPASS && wr_en && bus.Write_Register_i == a) ? {1'b0, bus.Write_Data_i} :
           {busy_q[a], mem_q[a]};
  endfunction
  assign {bus.Busy_1_o, bus.Read_Data_1_o} = rd(bus.Read_Register_1_i);
  assign {bus.Busy_2_o, bus.Read_Data_2_o} = rd(bus.Read_Register_2_i);
  assign bus.Clear_Busy_o = state_q == SWEEP;
endmodule
